// File: rtl/md_alu_pkg.sv
// Shared definitions for the md_alu multiply/divide unit: op encodings,
// controller state type and op classification helpers.
package md_alu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] code);
        return (code == OP_MULT) || (code == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] code);
        return (code == OP_DIV) || (code == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_alu_div.sv
// Combinational signed/unsigned divider for md_alu, only built when
// MD_ALU_DIV_EN is defined. Handles divide-by-zero and signed overflow.
module md_alu_div #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        a_neg  = is_signed & a[WIDTH-1];
        b_neg  = is_signed & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // Keep the divider operand nonzero so the unused path never goes X.
        b_safe = (b == '0) ? ONE : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end else if (is_signed && (a == MOST_NEG) && (b == '1)) begin
            quot = MOST_NEG;
            rem  = '0;
        end
    end

endmodule

// File: rtl/md_alu.sv
// HI/LO multiply-divide unit with fixed-latency MULT/MULTU/DIV/DIVU and
// direct MTHI/MTLO writes. Define MD_ALU_DIV_EN to build in the divider.
module md_alu
    import md_alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 accept;
    logic                 finish;
    logic                 long_op;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

`ifdef MD_ALU_DIV_EN
    logic [WIDTH-1:0]     div_quot;
    logic [WIDTH-1:0]     div_rem;

    md_alu_div #(.WIDTH(WIDTH)) u_div (
        .a         (a_q),
        .b         (b_q),
        .is_signed (op_q == OP_DIV),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    assign long_op = is_mul_op(op) || is_div_op(op);
`else
    assign long_op = is_mul_op(op);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter is loaded with N-1 so that RUN lasts exactly N cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && long_op) begin
                    accept     = 1'b1;
                    state_next = RUN;
                    cnt_next   = is_mul_op(op) ? MUL_LOAD : DIV_LOAD;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed product equals the low 2*WIDTH bits of the sign-extended product.
    always_comb begin
        if (op_q == OP_MULT) begin
            product = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            product = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
        res_hi = product[2*WIDTH-1:WIDTH];
        res_lo = product[WIDTH-1:0];
`ifdef MD_ALU_DIV_EN
        if (is_div_op(op_q)) begin
            res_hi = div_rem;
            res_lo = div_quot;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                op_q <= op;
                a_q  <= A;
                b_q  <= B;
            end
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE && start && op == OP_MTHI) begin
                hi <= A;
            end else if (state == IDLE && start && op == OP_MTLO) begin
                lo <= A;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_md_alu.sv
// Directed bench for md_alu: vector table for mult/div results and latency,
// plus hand sequences for back-to-back, ignored starts, MTHI/MTLO and reset.
module tb_md_alu;
    import md_alu_pkg::*;

    localparam int W     = 32;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op    = '0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    logic          start16 = 1'b0;
    logic [2:0]    op16    = '0;
    logic [15:0]   a16     = '0;
    logic [15:0]   b16     = '0;
    logic          busy16;
    logic          done16;
    logic [15:0]   hi16;
    logic [15:0]   lo16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    md_alu #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    md_alu #(.WIDTH(16), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .op    (op16),
        .A     (a16),
        .B     (b16),
        .busy  (busy16),
        .done  (done16),
        .hi    (hi16),
        .lo    (lo16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge inside the first busy cycle.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(7, 0));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int           cyc;
        int           n;
        logic [W-1:0] hi_prev;
        logic [W-1:0] lo_prev;
        string        tag;
        tag     = $sformatf("vec%0d", idx);
        n       = is_div_op(v.op) ? DIV_N : MUL_N;
        hi_prev = hi;
        lo_prev = lo;
        issue(v.op, v.a, v.b);
`ifndef MD_ALU_DIV_EN
        if (is_div_op(v.op)) begin
            check({tag, "_nodiv_busy"}, busy, 1'b0);
            repeat (DIV_N + 1) @(negedge clk);
            check({tag, "_nodiv_done"}, done, 1'b0);
            check({tag, "_nodiv_hi"}, hi, hi_prev);
            check({tag, "_nodiv_lo"}, lo, lo_prev);
            return;
        end
`endif
        wait_done(cyc);
        check({tag, "_cycles"}, cyc, n);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_hi"}, hi, v.exp_hi);
        check({tag, "_lo"}, lo, v.exp_lo);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic         seen;
        logic [W-1:0] lo_prev;
        logic [W-1:0] hi_prev;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{OP_MULTU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000};
        vecs[2]  = '{OP_MULT,  32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
        vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[5]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[10] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Back-to-back: second start issued while done is high.
        issue(OP_MULT, 32'd7, 32'd6);
        wait_done(cyc);
        check("b2b_first_done", done, 1'b1);
        check("b2b_first_lo", lo, 32'd42);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        check("b2b_second_busy", busy, 1'b1);
        check("b2b_second_done_low", done, 1'b0);
        wait_done(cyc);
        check("b2b_second_cycles", cyc, MUL_N);
        check("b2b_second_hi", hi, 32'h1);
        check("b2b_second_lo", lo, 32'hFFFF_FFFE);
        @(negedge clk);

        // MTLO while busy must be ignored.
        issue(OP_MULTU, 32'h8000_0000, 32'h4);
        lo_prev = lo;
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        check("busy_mtlo_lo", lo, lo_prev);
        check("busy_mtlo_busy", busy, 1'b1);
        wait_done(cyc);
        check("busy_mtlo_cycles", cyc, MUL_N - 1);
        check("busy_mtlo_res_hi", hi, 32'h2);
        check("busy_mtlo_res_lo", lo, 32'h0);
        @(negedge clk);

        // MTHI / MTLO from idle.
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", busy, 1'b0);
        check("mthi_done", done, 1'b0);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi_kept", hi, 32'h1234);
        check("mtlo_busy", busy, 1'b0);

        // Undefined op code.
        hi_prev = hi;
        lo_prev = lo;
        start = 1'b1;
        op    = 3'b110;
        a     = 32'hAAAA_5555;
        b     = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("undef_busy", busy, 1'b0);
        check("undef_hi", hi, hi_prev);
        check("undef_lo", lo, lo_prev);

        // Reset in the third busy cycle of a MULT.
        issue(OP_MULT, 32'd3, 32'd5);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (MUL_N + 3) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        check("abort_hi_after", hi, 32'h0);
        check("abort_lo_after", lo, 32'h0);

        // 16-bit instance: signed and unsigned multiply.
        start16 = 1'b1;
        op16    = OP_MULT;
        a16     = 16'hFFFE;
        b16     = 16'h0003;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (busy16 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("w16_mult_cycles", cyc, MUL_N);
        check("w16_mult_done", done16, 1'b1);
        check("w16_mult_hi", hi16, 16'hFFFF);
        check("w16_mult_lo", lo16, 16'hFFFA);
        start16 = 1'b1;
        op16    = OP_MULTU;
        a16     = 16'h8000;
        b16     = 16'h0004;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (busy16 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("w16_multu_cycles", cyc, MUL_N);
        check("w16_multu_hi", hi16, 16'h0002);
        check("w16_multu_lo", lo16, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_alu.md
MD_ALU -- requirements
Module: md_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits (8..64).
REQ-002 SHALL provide parameter MUL_CYCLES, default 5, multiply latency in cycles (>=1).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, divide latency in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-007 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-008 SHALL have port A  input  WIDTH  operand A (dividend / write data).
REQ-009 SHALL have port B  input  WIDTH  operand B (divisor).
REQ-010 SHALL have port busy  output  1  high while a multiply or divide is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the cycle hi/lo take a mult/div result.
REQ-012 SHALL have port hi  output  WIDTH  HI register.
REQ-013 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE->RUN on start with MULT/MULTU/DIV/DIVU; RUN->IDLE when the latency counter expires.
REQ-015 SHALL latch op, A and B at the accepting edge; later input changes SHALL NOT affect the result.
REQ-016 SHALL assert busy from the cycle after acceptance for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES), updating hi/lo and pulsing done at the edge ending the Nth cycle.
REQ-017 SHALL accept a new start in the same cycle that done is high (back-to-back, no idle bubble required).
REQ-018 SHALL ignore start while busy=1; hi/lo and the in-flight operation SHALL be unaffected.
REQ-019 MULT/MULTU SHALL produce the full 2*WIDTH product, signed/unsigned respectively; hi=upper WIDTH bits, lo=lower WIDTH bits.
REQ-020 DIV/DIVU SHALL produce lo=quotient truncated toward zero, hi=remainder with the sign of A (signed) or unsigned.
REQ-021 Divide by zero SHALL give lo=all ones, hi=A, with normal latency and done.
REQ-022 Signed DIV of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-023 MTHI/MTLO with busy=0 SHALL write A into hi/lo at the accepting edge, never assert busy or done.
REQ-024 Undefined op codes with start SHALL be no-ops (no state change).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, including mid-operation; the aborted result SHALL never appear.
REQ-026 After rst_n deasserts the first rising edge SHALL be able to accept start.

Configuration
REQ-027 Macro MD_ALU_DIV_EN defined SHALL compile in the divider and DIV/DIVU behaviour above.
REQ-028 Without MD_ALU_DIV_EN, DIV/DIVU SHALL be no-ops per REQ-024 and no divider logic SHALL be synthesised.

Structure
REQ-029 Package md_alu_pkg SHALL hold op encodings and the IDLE/RUN state type.
REQ-030 Divide arithmetic (signed/unsigned, zero and overflow cases) SHALL live in sub-module md_alu_div, instantiated only under MD_ALU_DIV_EN.

Verification
REQ-031 MULT A=32'hFFFF_FFFE (-2), B=3 -> busy 5 cycles, done pulse, hi=FFFF_FFFF, lo=FFFF_FFFA.
REQ-032 MULTU A=32'h8000_0000, B=4 -> hi=2, lo=0 after 5 cycles; start with MTLO during busy ignored.
REQ-033 DIV A=-7, B=2 -> after 10 cycles lo=FFFF_FFFD (-3), hi=FFFF_FFFF (-1); DIVU A=7, B=0 -> lo=FFFF_FFFF, hi=7.
REQ-034 DIV A=32'h8000_0000, B=FFFF_FFFF -> lo=8000_0000, hi=0; MTHI A=1234 -> hi=1234 next edge, busy stays 0.
REQ-035 rst_n pulled low in cycle 3 of a MULT -> busy/done/hi/lo 0 immediately, no done after release.
REQ-036 Without MD_ALU_DIV_EN, DIV start -> busy stays 0, hi/lo unchanged; WIDTH=16 build repeats REQ-031 with 16-bit values.
